// File: rtl/motor_pkg.sv
// Shared definitions for the step/dir motor blocks (pulse generators and decoders).
// Holds the decoder FSM state encoding, the period counter width, the position
// width agreed between generator and decoder, and a saturating increment helper.
package motor_pkg;

  localparam int unsigned PERIOD_WIDTH    = 16;
  localparam int unsigned MOTOR_POS_WIDTH = 19;

  typedef enum logic [1:0] {
    StWaitHigh = 2'd0,
    StQualify  = 2'd1,
    StWaitLow  = 2'd2
  } decState_e;

  function automatic logic [PERIOD_WIDTH-1:0] satInc(input logic [PERIOD_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_filter.sv
// N-stage flop synchronizer for a single asynchronous input.
// Ports:
//   CLK   - destination clock
//   reset - asynchronous active-high reset, clears the chain to 0
//   d     - asynchronous input
//   q     - synchronized output (last flop of the chain)
module sync_filter #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] syncQ;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      syncQ <= '0;
    end else begin
      syncQ <= {syncQ[STAGES-2:0], d};
    end
  end

  assign q = syncQ[STAGES-1];

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir input decoder: turns an external step/dir pulse stream into a signed
// position count, a measured step period and a motion flag.
// Ports:
//   CLK, reset          - system clock, asynchronous active-high reset
//   stepIn, dirIn       - raw asynchronous step pulse and direction
//   dirInvert           - quasi-static count-direction inversion
//   clearPos, clearErr  - synchronous clears of position and dirSetupErr
//   position            - signed accumulated step count (wraps)
//   period, periodValid - cycles between last two accepted steps, update pulse
//   stepStrobe          - one-cycle pulse per accepted step
//   dir                 - post-inversion direction of the last accepted step
//   activeMode          - motion present
//   dirSetupErr         - sticky flag: step accepted before dir was stable
module step_dir_decoder
  import motor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned MIN_HIGH     = 2,
  parameter int unsigned DIR_SETUP    = 8,
  parameter int unsigned IDLE_TIMEOUT = 16'hFFFF,
  parameter int unsigned POS_WIDTH    = MOTOR_POS_WIDTH
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        stepIn,
  input  logic                        dirIn,
  input  logic                        dirInvert,
  input  logic                        clearPos,
  input  logic                        clearErr,
  output logic signed [POS_WIDTH-1:0] position,
  output logic [PERIOD_WIDTH-1:0]     period,
  output logic                        periodValid,
  output logic                        stepStrobe,
  output logic                        dir,
  output logic                        activeMode,
  output logic                        dirSetupErr
);

  localparam logic [3:0]              MinHigh       = 4'(MIN_HIGH);
  localparam logic [7:0]              DirSetupLimit = 8'(DIR_SETUP);
  localparam logic [PERIOD_WIDTH-1:0] IdleLimit     = PERIOD_WIDTH'(IDLE_TIMEOUT);

  logic stepS, dirS;

  sync_filter #(.STAGES(SYNC_STAGES)) uStepSync (
    .CLK   (CLK),
    .reset (reset),
    .d     (stepIn),
    .q     (stepS)
  );

  sync_filter #(.STAGES(SYNC_STAGES)) uDirSync (
    .CLK   (CLK),
    .reset (reset),
    .d     (dirIn),
    .q     (dirS)
  );

  // Pulse qualifier FSM
  decState_e stateQ, stateD;
  logic [3:0] qualCntQ, qualCntD;
  logic       accept;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      stateQ   <= StWaitHigh;
      qualCntQ <= '0;
    end else begin
      stateQ   <= stateD;
      qualCntQ <= qualCntD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    qualCntD = qualCntQ;
    accept   = 1'b0;
    unique case (stateQ)
      StWaitHigh: begin
        if (stepS) begin
          if (MinHigh == 4'd1) begin
            accept = 1'b1;
            stateD = StWaitLow;
          end else begin
            qualCntD = 4'd1;
            stateD   = StQualify;
          end
        end
      end
      StQualify: begin
        if (!stepS) begin
          stateD = StWaitHigh;  // glitch rejected
        end else begin
          qualCntD = qualCntQ + 4'd1;
          if (qualCntD == MinHigh) begin
            accept = 1'b1;
            stateD = StWaitLow;
          end
        end
      end
      StWaitLow: begin
        // A held-high step counts once; re-arm only after it goes low.
        if (!stepS) stateD = StWaitHigh;
      end
      default: stateD = StWaitHigh;
    endcase
  end

  // Datapath registers
  logic signed [POS_WIDTH-1:0] positionQ, positionD;
  logic [PERIOD_WIDTH-1:0]     periodQ, periodD;
  logic [PERIOD_WIDTH-1:0]     periodCntQ, periodCntD;
  logic                        periodValidQ, periodValidD;
  logic                        strobeQ;
  logic                        dirQ, dirD;
  logic                        activeQ, activeD;
  logic                        errQ, errD;
  logic [7:0]                  dirStableQ, dirStableD;
  logic                        dirSPrevQ;

  logic                        stepUp;
  logic signed [POS_WIDTH-1:0] posStep;

  always_comb begin
    stepUp  = dirS ^ dirInvert;
    posStep = stepUp ? POS_WIDTH'(1) : '1;

    // Clear first, then apply a coincident step.
    positionD = clearPos ? '0 : positionQ;
    if (accept) positionD = positionD + posStep;

    periodCntD   = accept ? PERIOD_WIDTH'(1) : satInc(periodCntQ);
    periodValidD = accept && activeQ;  // first step after idle only arms
    periodD      = periodValidD ? periodCntQ : periodQ;

    activeD = activeQ;
    if (accept) begin
      activeD = 1'b1;
    end else if (periodCntD >= IdleLimit) begin
      activeD = 1'b0;
    end

    dirD = accept ? stepUp : dirQ;

    if (dirS != dirSPrevQ) begin
      dirStableD = '0;
    end else if (dirStableQ < DirSetupLimit) begin
      dirStableD = dirStableQ + 8'd1;
    end else begin
      dirStableD = dirStableQ;
    end

    // A new violation wins over a coincident clear.
    errD = (errQ & ~clearErr) | (accept && (dirStableQ < DirSetupLimit));
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      positionQ    <= '0;
      periodQ      <= '0;
      periodCntQ   <= '0;
      periodValidQ <= 1'b0;
      strobeQ      <= 1'b0;
      dirQ         <= 1'b0;
      activeQ      <= 1'b0;
      errQ         <= 1'b0;
      dirStableQ   <= '0;
      dirSPrevQ    <= 1'b0;
    end else begin
      positionQ    <= positionD;
      periodQ      <= periodD;
      periodCntQ   <= periodCntD;
      periodValidQ <= periodValidD;
      strobeQ      <= accept;
      dirQ         <= dirD;
      activeQ      <= activeD;
      errQ         <= errD;
      dirStableQ   <= dirStableD;
      dirSPrevQ    <= dirS;
    end
  end

  assign position    = positionQ;
  assign period      = periodQ;
  assign periodValid = periodValidQ;
  assign stepStrobe  = strobeQ;
  assign dir         = dirQ;
  assign activeMode  = activeQ;
  assign dirSetupErr = errQ;

endmodule

// File: doc/step_dir_decoder.md
# step_dir_decoder

Receives an external step/dir pulse stream, as produced by the team's step/dir motor pulse generators, and turns it into a signed position count, a measured step period and a motion flag. It sits on the input side of the design, behind the board pins. It monitors a drive channel, or accepts commands from an upstream controller, and feeds position/velocity registers. Inputs are asynchronous to CLK; all outputs are registered in the CLK domain.

## Interface
- SYNC_STAGES, 2, synchronizer flops on stepIn and dirIn (≥2)
- MIN_HIGH, 2, consecutive synchronized-high cycles required to accept a step (1..15)
- DIR_SETUP, 8, cycles dir must be stable before an accepted step (0..255)
- IDLE_TIMEOUT, 16'hFFFF, cycles without a step before motion is declared stopped (≥2)
- POS_WIDTH, 19, position counter width
- CLK  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- stepIn  in  1  raw step pulse, asynchronous
- dirIn  in  1  raw direction, asynchronous; 1 = count up before inversion
- dirInvert  in  1  quasi-static; inverts the count direction
- clearPos  in  1  synchronous; zeroes position
- clearErr  in  1  synchronous; clears dirSetupErr
- position  out  POS_WIDTH  signed accumulated step count
- period  out  16  cycles between the last two accepted steps
- periodValid  out  1  one-cycle pulse when period updates
- stepStrobe  out  1  one-cycle pulse per accepted step
- dir  out  1  direction applied to the last accepted step (post-inversion)
- activeMode  out  1  motion present
- dirSetupErr  out  1  sticky dir-setup violation flag

## Operation
- Reset values: position 0, period 0, periodValid 0, stepStrobe 0, dir 0, activeMode 0, dirSetupErr 0, state WAIT_HIGH, periodCnt 0, dirStableCnt 0.
- stepIn and dirIn pass through SYNC_STAGES flops. The flop outputs are stepS and dirS.
- FSM:
  - WAIT_HIGH: when stepS=1, qualCnt←1 and go to QUALIFY. If MIN_HIGH=1, accept immediately and go to WAIT_LOW.
  - QUALIFY: if stepS=0, return to WAIT_HIGH without counting (glitch rejected). Otherwise increment qualCnt. On reaching MIN_HIGH, accept and go to WAIT_LOW.
  - WAIT_LOW: when stepS=0, go to WAIT_HIGH. A step held high forever counts once.
- Accept actions, all on the same edge:
  - stepStrobe←1.
  - dir←dirS^dirInvert.
  - position←position±1: +1 when dirS^dirInvert=1. Two's-complement wrap, no saturation.
  - activeMode←1.
- Period:
  - periodCnt increments every cycle and saturates at 16'hFFFF.
  - On accept: if activeMode was already 1, period←periodCnt and periodValid←1. In every case periodCnt←1.
  - The first step after idle or reset only arms the measurement; it produces no periodValid.
- Idle: when periodCnt reaches IDLE_TIMEOUT with no accept on that edge, activeMode←0.
- Dir setup:
  - dirStableCnt clears to 0 on any dirS change, otherwise increments and saturates at DIR_SETUP.
  - If accept occurs with dirStableCnt<DIR_SETUP, dirSetupErr←1. The step still counts, using the current dirS.
- Simultaneous events:
  - clearPos with accept: position←±1 (clear, then apply).
  - clearErr with a new violation: set wins.
  - clearPos/clearErr without other events take effect the next edge.
- Reset mid-pulse: returns to WAIT_HIGH. A stepIn still high after reset release is treated as a new pulse and counted once qualified.

## Timing
- Accept latency: stepIn first sampled high at edge N gives stepStrobe, position and dir updates visible after edge N+SYNC_STAGES+MIN_HIGH-1 (edge N+3 with defaults).
- Minimum resolvable input: high ≥ MIN_HIGH+1 cycles, low ≥ 2 cycles.
- Period: a clean train with spacing P cycles reports period=P, clamped to 65535.
- activeMode falls IDLE_TIMEOUT-1 cycles after the last accept edge.
- stepStrobe and periodValid are never high for two consecutive cycles.

## Structure
- Shared package (motor_pkg): FSM state encoding for WAIT_HIGH/QUALIFY/WAIT_LOW and the PERIOD_WIDTH=16 constant. The package also holds the position width shared with the pulse generator, so both ends agree.
- One natural sub-module: sync_filter, a parameterized N-stage synchronizer instantiated twice, for stepIn and dirIn. Everything else lives in a single always block plus counters.

## Test plan
- Reset then 10 pulses, dirIn=1, 4 high/6 low (P=10) -> position=10, 10 stepStrobes, 9 periodValid each with period=10, activeMode=1.
- Same train with dirIn=0, then dirInvert=1 with dirIn=0 -> position returns 10→0, then rises to 10.
- 1-cycle stepIn glitches, MIN_HIGH=2 -> no stepStrobe, position unchanged. A 1000-cycle-high pulse -> exactly one count.
- dirIn toggled 3 cycles before a step, DIR_SETUP=8 -> dirSetupErr=1, the step is counted with the new direction. clearErr on the same cycle as a second violation -> flag stays 1.
- position preset to 2^18-1 via up-steps, one more up step -> wraps to -2^18. clearPos coincident with an up step -> position=1.
- IDLE_TIMEOUT=100, then stop the train -> activeMode falls 99 cycles after the last accept. The next step gives no periodValid. Assert reset mid-QUALIFY -> all outputs return to reset values on the same cycle.
